// File: rtl/control_sequencer_pkg.sv
// cpu_ctrl_pkg: states, opcodes and IR field positions shared by the control sequencer files
package cpu_ctrl_pkg;
  typedef logic [2:0] state_t;
  localparam state_t RESET_S = 3'd0;
  localparam state_t T0 = 3'd1;
  localparam state_t T1 = 3'd2;
  localparam state_t T2 = 3'd3;
  localparam state_t T3 = 3'd4;
  localparam state_t T4 = 3'd5;
  localparam state_t T5 = 3'd6;
  localparam state_t HALT_S = 3'd7;
  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_SUB = 5'b00100;
  localparam logic [4:0] OP_AND = 5'b00101;
  localparam logic [4:0] OP_OR = 5'b00110;
  localparam logic [4:0] OP_SHR = 5'b00111;
  localparam logic [4:0] OP_SHL = 5'b01000;
  localparam logic [4:0] OP_NEG = 5'b10001;
  localparam logic [4:0] OP_NOT = 5'b10010;
  localparam logic [4:0] OP_NOP = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;
  localparam int OP_MSB = 31;
  localparam int RA_MSB = 26;
  localparam int RB_MSB = 22;
  localparam int RC_MSB = 18;
  localparam int IDXW = 4;
  function automatic logic is_unary(input logic [4:0] op);
    return op == OP_NEG || op == OP_NOT;
  endfunction
  function automatic logic is_binary(input logic [4:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL};
  endfunction
endpackage

// File: rtl/control_sequencer_if.sv
// control_sequencer_if: IR/mem_ready inputs and datapath strobes between sequencer (master) and bus (slave)
// Optional illegal flag present when CTRL_ILLEGAL_TRAP_EN is defined.
interface control_sequencer_if #(parameter int NREGS = 16, parameter int OPW = 5);
  logic [31:0] ir;
  logic mem_ready;
  logic PCout, MARin, IncPC, Zlowin, ZLOout, PCin, read, MDRin, MDRout, IRin, Yin;
  logic [NREGS-1:0] reg_in, reg_out;
  logic [OPW-1:0] operation;
  logic run;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal;
`endif
  modport master(
    input ir, mem_ready,
`ifdef CTRL_ILLEGAL_TRAP_EN
    output illegal,
`endif
    output PCout, MARin, IncPC, Zlowin, ZLOout, PCin, read, MDRin, MDRout, IRin, Yin,
    output reg_in, reg_out, operation, run
  );
  modport slave(
    output ir, mem_ready,
`ifdef CTRL_ILLEGAL_TRAP_EN
    input illegal,
`endif
    input PCout, MARin, IncPC, Zlowin, ZLOout, PCin, read, MDRin, MDRout, IRin, Yin,
    input reg_in, reg_out, operation, run
  );
endinterface

// File: rtl/control_sequencer_reg_select.sv
// reg_select: 4-bit register index plus enable to NREGS-wide one-hot (all zero when disabled)
// Ports: idx in 4, en in 1, onehot out NREGS.
module reg_select #(parameter int NREGS = 16) (
  input logic [3:0] idx,
  input logic en,
  output logic [NREGS-1:0] onehot
);
  assign onehot = en ? {{(NREGS-1){1'b0}}, 1'b1} << idx : '0;
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired Moore control unit sequencing fetch T0-T2 and execute T3-T5
// Ports: clock (rising edge), clear (async active-low), cs (control_sequencer_if.master: ir, mem_ready in; strobes, reg_in, reg_out, operation, run out).
// Define CTRL_ILLEGAL_TRAP_EN to halt on illegal opcodes and expose the sticky illegal flag.
module control_sequencer import cpu_ctrl_pkg::*; #(
  parameter int NREGS = 16,
  parameter int OPW = 5
) (
  input logic clock,
  input logic clear,
  control_sequencer_if.master cs
);
  state_t state, next;
  logic [OPW-1:0] op;
  logic [IDXW-1:0] ra, rb, rc;
  logic un, bin, stop, unused;
  logic t0, t1, t2, t3, t4, t5;
  assign op = cs.ir[OP_MSB -: OPW];
  assign ra = cs.ir[RA_MSB -: IDXW];
  assign rb = cs.ir[RB_MSB -: IDXW];
  assign rc = cs.ir[RC_MSB -: IDXW];
  assign unused = ^cs.ir[14:0];
  assign un = is_unary(op);
  assign bin = is_binary(op);
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic ill_op, illegal_q;
  assign ill_op = !(un || bin || op == OP_NOP || op == OP_HALT);
  assign stop = op == OP_HALT || ill_op;
  always_ff @(posedge clock or negedge clear)
    if (!clear) illegal_q <= 1'b0;
    else if (t3 && ill_op) illegal_q <= 1'b1;
  assign cs.illegal = illegal_q;
`else
  assign stop = op == OP_HALT;
`endif
  always_ff @(posedge clock or negedge clear)
    if (!clear) state <= RESET_S;
    else state <= next;
  always_comb begin
    next = state == RESET_S ? T0 :
           state == T0 ? T1 :
           state == T1 ? (cs.mem_ready ? T2 : T1) :
           state == T2 ? T3 :
           state == T3 ? (stop ? HALT_S : (un || bin) ? T4 : T0) :
           state == T4 ? (bin ? T5 : T0) :
           state == T5 ? T0 : HALT_S;
  end
  assign t0 = state == T0;
  assign t1 = state == T1;
  assign t2 = state == T2;
  assign t3 = state == T3;
  assign t4 = state == T4;
  assign t5 = state == T5;
  assign cs.PCout = t0;
  assign cs.MARin = t0;
  assign cs.IncPC = t0;
  assign cs.Zlowin = t0 || (t3 && un) || (t4 && bin);
  assign cs.ZLOout = t1 || (t4 && un) || t5;
  assign cs.PCin = t1;
  assign cs.read = t1;
  assign cs.MDRin = t1;
  assign cs.MDRout = t2;
  assign cs.IRin = t2;
  assign cs.Yin = t3 && bin;
  assign cs.operation = ((t3 && un) || (t4 && bin)) ? op : '0;
  assign cs.run = state != RESET_S && state != HALT_S;
  reg_select #(.NREGS(NREGS)) u_out (.idx(t4 ? rc : rb), .en((t3 && (un || bin)) || (t4 && bin)), .onehot(cs.reg_out));
  reg_select #(.NREGS(NREGS)) u_in (.idx(ra), .en((t4 && un) || t5), .onehot(cs.reg_in));
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed checks of fetch, unary/binary execute, stall, halt, reset and illegal opcodes
module tb_control_sequencer;
  logic clock = 1'b0;
  logic clear = 1'b0;
  int total = 0;
  int bad = 0;
  control_sequencer_if #(.NREGS(16), .OPW(5)) cs();
  control_sequencer #(.NREGS(16), .OPW(5)) dut (.clock(clock), .clear(clear), .cs(cs));
  always #5 clock = ~clock;
  logic [10:0] sb;
  assign sb = {cs.PCout, cs.MARin, cs.IncPC, cs.Zlowin, cs.ZLOout, cs.PCin, cs.read, cs.MDRin, cs.MDRout, cs.IRin, cs.Yin};
  localparam logic [10:0] S_T0 = 11'b11110000000;
  localparam logic [10:0] S_T1 = 11'b00001111000;
  localparam logic [10:0] S_T2 = 11'b00000000110;
  localparam logic [10:0] S_ZI = 11'b00010000000;
  localparam logic [10:0] S_ZO = 11'b00001000000;
  localparam logic [10:0] S_Y = 11'b00000000001;
  localparam logic [31:0] IR_NEG = 32'h88080000;
  localparam logic [31:0] IR_ADD = 32'h191A0000;
  localparam logic [31:0] IR_HALT = 32'hD8000000;
  localparam logic [31:0] IR_ILL = 32'hF8000000;

  task automatic test_reset();
    clear = 1'b0;
    cs.ir = IR_NEG;
    cs.mem_ready = 1'b1;
    repeat (2) @(negedge clock);
    total++; if (sb !== 11'd0) begin bad++; $display("FAIL reset_strobes got=%b exp=%b", sb, 11'd0); end
    total++; if (cs.reg_in !== 16'h0 || cs.reg_out !== 16'h0) begin bad++; $display("FAIL reset_regs got in=%h out=%h exp 0", cs.reg_in, cs.reg_out); end
    total++; if (cs.operation !== 5'b0 || cs.run !== 1'b0) begin bad++; $display("FAIL reset_op_run got op=%b run=%b exp 0", cs.operation, cs.run); end
`ifdef CTRL_ILLEGAL_TRAP_EN
    total++; if (cs.illegal !== 1'b0) begin bad++; $display("FAIL reset_illegal got=%b exp=0", cs.illegal); end
`endif
    clear = 1'b1;
    @(negedge clock);
    total++; if (sb !== S_T0 || cs.run !== 1'b1) begin bad++; $display("FAIL first_t0 got=%b run=%b exp=%b run=1", sb, cs.run, S_T0); end
  endtask

  task automatic test_neg();
    @(negedge clock);
    total++; if (sb !== S_T1) begin bad++; $display("FAIL neg_t1 got=%b exp=%b", sb, S_T1); end
    @(negedge clock);
    total++; if (sb !== S_T2) begin bad++; $display("FAIL neg_t2 got=%b exp=%b", sb, S_T2); end
    @(negedge clock);
    total++; if (sb !== S_ZI || cs.reg_out !== 16'h0002 || cs.operation !== 5'b10001 || cs.reg_in !== 16'h0) begin bad++; $display("FAIL neg_t3 got sb=%b out=%h op=%b in=%h exp sb=%b out=0002 op=10001 in=0000", sb, cs.reg_out, cs.operation, cs.reg_in, S_ZI); end
    @(negedge clock);
    total++; if (sb !== S_ZO || cs.reg_in !== 16'h0001 || cs.reg_out !== 16'h0 || cs.operation !== 5'b0) begin bad++; $display("FAIL neg_t4 got sb=%b in=%h out=%h op=%b exp sb=%b in=0001 out=0000 op=00000", sb, cs.reg_in, cs.reg_out, cs.operation, S_ZO); end
    @(negedge clock);
    total++; if (sb !== S_T0 || cs.operation !== 5'b0) begin bad++; $display("FAIL neg_back_t0 got=%b op=%b exp=%b", sb, cs.operation, S_T0); end
  endtask

  task automatic test_add();
    cs.ir = IR_ADD;
    repeat (3) @(negedge clock);
    total++; if (sb !== S_Y || cs.reg_out !== 16'h0008 || cs.operation !== 5'b0) begin bad++; $display("FAIL add_t3 got sb=%b out=%h op=%b exp sb=%b out=0008 op=00000", sb, cs.reg_out, cs.operation, S_Y); end
    @(negedge clock);
    total++; if (sb !== S_ZI || cs.reg_out !== 16'h0010 || cs.operation !== 5'b00011 || cs.reg_in !== 16'h0) begin bad++; $display("FAIL add_t4 got sb=%b out=%h op=%b in=%h exp sb=%b out=0010 op=00011 in=0000", sb, cs.reg_out, cs.operation, cs.reg_in, S_ZI); end
    @(negedge clock);
    total++; if (sb !== S_ZO || cs.reg_in !== 16'h0004 || cs.reg_out !== 16'h0) begin bad++; $display("FAIL add_t5 got sb=%b in=%h out=%h exp sb=%b in=0004 out=0000", sb, cs.reg_in, cs.reg_out, S_ZO); end
    @(negedge clock);
    total++; if (sb !== S_T0) begin bad++; $display("FAIL add_back_t0 got=%b exp=%b", sb, S_T0); end
  endtask

  task automatic test_stall();
    cs.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      total++; if (sb !== S_T1) begin bad++; $display("FAIL stall_t1_%0d got=%b exp=%b", i, sb, S_T1); end
      if (i == 3) cs.mem_ready = 1'b1;
    end
    @(negedge clock);
    total++; if (sb !== S_T2) begin bad++; $display("FAIL stall_t2 got=%b exp=%b", sb, S_T2); end
    repeat (4) @(negedge clock);
    total++; if (sb !== S_T0) begin bad++; $display("FAIL stall_back_t0 got=%b exp=%b", sb, S_T0); end
  endtask

  task automatic test_halt();
    cs.ir = IR_HALT;
    repeat (3) @(negedge clock);
    total++; if (sb !== 11'd0 || cs.run !== 1'b1 || cs.reg_out !== 16'h0) begin bad++; $display("FAIL halt_t3 got sb=%b run=%b out=%h exp sb=0 run=1 out=0000", sb, cs.run, cs.reg_out); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      total++; if (sb !== 11'd0 || cs.run !== 1'b0 || cs.operation !== 5'b0) begin bad++; $display("FAIL halt_hold_%0d got sb=%b run=%b op=%b exp all 0", i, sb, cs.run, cs.operation); end
    end
    clear = 1'b0;
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    total++; if (sb !== S_T0 || cs.run !== 1'b1) begin bad++; $display("FAIL halt_restart got=%b run=%b exp=%b run=1", sb, cs.run, S_T0); end
  endtask

  task automatic test_reset_mid();
    cs.ir = IR_NEG;
    repeat (4) @(negedge clock);
    total++; if (cs.reg_in !== 16'h0001 || sb !== S_ZO) begin bad++; $display("FAIL mid_t4 got in=%h sb=%b exp in=0001 sb=%b", cs.reg_in, sb, S_ZO); end
    #2 clear = 1'b0;
    #1;
    total++; if (sb !== 11'd0 || cs.reg_in !== 16'h0 || cs.run !== 1'b0) begin bad++; $display("FAIL mid_async got sb=%b in=%h run=%b exp all 0", sb, cs.reg_in, cs.run); end
    @(negedge clock);
    clear = 1'b1;
    #1;
    total++; if (sb !== 11'd0 || cs.run !== 1'b0) begin bad++; $display("FAIL mid_reset_s got sb=%b run=%b exp 0", sb, cs.run); end
    @(negedge clock);
    total++; if (sb !== S_T0) begin bad++; $display("FAIL mid_t0 got=%b exp=%b", sb, S_T0); end
  endtask

  task automatic test_illegal();
    cs.ir = IR_ILL;
    repeat (3) @(negedge clock);
    total++; if (sb !== 11'd0 || cs.run !== 1'b1 || cs.operation !== 5'b0) begin bad++; $display("FAIL ill_t3 got sb=%b run=%b op=%b exp sb=0 run=1 op=0", sb, cs.run, cs.operation); end
    @(negedge clock);
`ifdef CTRL_ILLEGAL_TRAP_EN
    total++; if (sb !== 11'd0 || cs.run !== 1'b0 || cs.illegal !== 1'b1) begin bad++; $display("FAIL ill_trap got sb=%b run=%b illegal=%b exp sb=0 run=0 illegal=1", sb, cs.run, cs.illegal); end
    repeat (2) @(negedge clock);
    total++; if (cs.illegal !== 1'b1 || cs.run !== 1'b0) begin bad++; $display("FAIL ill_sticky got illegal=%b run=%b exp 1/0", cs.illegal, cs.run); end
`else
    total++; if (sb !== S_T0 || cs.run !== 1'b1) begin bad++; $display("FAIL ill_nop got sb=%b run=%b exp=%b run=1", sb, cs.run, S_T0); end
`endif
  endtask

  initial begin
    test_reset();
    test_neg();
    test_add();
    test_stall();
    test_halt();
    test_reset_mid();
    test_illegal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
